// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: debounces NumBtn buttons on a shared tick and queues press/release/long-press events.
// Long-press detection is built only when BTN_EVT_LONG_PRESS_EN is defined.
module btn_event_ctrl #(
  parameter int NumBtn         = 4,
  parameter int TickCount      = 500,
  parameter int DebounceTicks  = 4,
  parameter int LongPressTicks = 256,
  parameter int FifoDepth      = 4,
  localparam int IdW = (NumBtn > 1) ? $clog2(NumBtn) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumBtn-1:0] btn_i,
  output logic [NumBtn-1:0] btn_state_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [IdW-1:0]    evt_id_o,
  output logic [1:0]        evt_type_o,
  output logic              evt_overflow_o,
  input  logic              overflow_clr_i
);
  localparam int TW = $clog2(TickCount);
  localparam int DW = $clog2(DebounceTicks + 1);
  localparam int AW = $clog2(FifoDepth);

  logic [NumBtn-1:0] sync1_q, sync2_q, state_q, state_d;
  logic [TW-1:0]     pre_q, pre_d;
  logic [DW-1:0]     db_q [NumBtn];
  logic [DW-1:0]     db_d [NumBtn];
  logic [NumBtn-1:0] press_ev, rel_ev;
  logic [NumBtn-1:0] press_q, press_d, rel_q, rel_d, long_q;
  logic [NumBtn-1:0] any_pend, sel, clr_press, clr_rel, drop_long;
  logic [IdW-1:0]    sel_id;
  logic [1:0]        sel_type;
  logic              tick, push, pop, full, empty, ovf_q, ovf_d;
  logic [AW:0]       wp_q, wp_d, rp_q, rp_d;
  logic [IdW+1:0]    mem_q [FifoDepth];

  assign tick  = pre_q == TW'(TickCount - 1);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    press_ev = '0;
    rel_ev   = '0;
    for (int i = 0; i < NumBtn; i++) begin
      db_d[i] = db_q[i];
      if (tick) begin
        if (sync2_q[i] == state_q[i]) begin
          db_d[i] = '0;
        end else if (db_q[i] == DW'(DebounceTicks - 1)) begin
          db_d[i]     = '0;
          state_d[i]  = sync2_q[i];
          press_ev[i] = sync2_q[i];
          rel_ev[i]   = !sync2_q[i];
        end else begin
          db_d[i] = db_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_EVT_LONG_PRESS_EN
  localparam int LW = $clog2(LongPressTicks + 1);
  logic [LW-1:0]     hold_q [NumBtn];
  logic [LW-1:0]     hold_d [NumBtn];
  logic [NumBtn-1:0] long_ev, long_d, clr_long;

  // Hold count saturates, so the long event fires once per press.
  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      hold_d[i]  = !state_q[i] ? '0 :
                   (tick && hold_q[i] != LW'(LongPressTicks)) ? hold_q[i] + 1'b1 : hold_q[i];
      long_ev[i] = tick && state_q[i] && hold_q[i] == LW'(LongPressTicks - 1);
    end
  end

  assign clr_long  = (push && sel_type == 2'd2) ? sel : '0;
  assign drop_long = long_ev & long_q & ~clr_long;
  assign long_d    = (long_q & ~clr_long) | long_ev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      long_q <= '0;
      for (int i = 0; i < NumBtn; i++) hold_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < NumBtn; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  assign long_q    = '0;
  assign drop_long = '0;
`endif

  assign any_pend = press_q | rel_q | long_q;
  assign sel      = any_pend & (~any_pend + NumBtn'(1));
  assign sel_type = |(sel & press_q) ? 2'd0 : |(sel & long_q) ? 2'd2 : 2'd1;

  always_comb begin
    sel_id = '0;
    for (int i = NumBtn - 1; i >= 0; i--) if (any_pend[i]) sel_id = IdW'(i);
  end

  assign clr_press = (push && sel_type == 2'd0) ? sel : '0;
  assign clr_rel   = (push && sel_type == 2'd1) ? sel : '0;
  assign press_d   = (press_q & ~clr_press) | press_ev;
  assign rel_d     = (rel_q & ~clr_rel) | rel_ev;
  // A flag still set (and not being drained this cycle) means the new event is lost.
  assign ovf_d     = |(press_ev & press_q & ~clr_press) | |(rel_ev & rel_q & ~clr_rel) |
                     |drop_long | (ovf_q & ~overflow_clr_i);

  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign push  = |any_pend && !full;
  assign pop   = !empty && evt_ready_i;
  assign wp_d  = wp_q + {{AW{1'b0}}, push};
  assign rp_d  = rp_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q[AW-1:0]] <= {sel_id, sel_type};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= '0;
      pre_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      for (int i = 0; i < NumBtn; i++) db_q[i] <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      pre_q   <= pre_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      ovf_q   <= ovf_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      for (int i = 0; i < NumBtn; i++) db_q[i] <= db_d[i];
    end
  end

  assign btn_state_o              = state_q;
  assign evt_valid_o              = !empty;
  assign {evt_id_o, evt_type_o}   = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign evt_overflow_o           = ovf_q;
endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: directed checks of debounce, event ordering, backpressure, overflow and reset.
module tb_btn_event_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] btn_i = '0;
  logic [3:0] btn_state_o;
  logic       evt_valid_o;
  logic       evt_ready_i = 1'b0;
  logic [1:0] evt_id_o;
  logic [1:0] evt_type_o;
  logic       evt_overflow_o;
  logic       overflow_clr_i = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;
  int         evq[$];
  logic       seen;

  always #5 clk_i = ~clk_i;

  btn_event_ctrl #(
    .NumBtn(4), .TickCount(4), .DebounceTicks(3), .LongPressTicks(8), .FifoDepth(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_i), .btn_state_o(btn_state_o),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_id_o(evt_id_o),
    .evt_type_o(evt_type_o), .evt_overflow_o(evt_overflow_o), .overflow_clr_i(overflow_clr_i)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Head encoded as id*4+type, or -1 when empty.
  function automatic int head();
    return evt_valid_o ? int'(evt_id_o) * 4 + int'(evt_type_o) : -1;
  endfunction

  task automatic wait_state(input int ch, input logic v, input int lim, input string tag);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_i);
      if (btn_state_o[ch] == v) break;
    end
    chk(tag, int'(btn_state_o[ch]), int'(v));
  endtask

  task automatic toggle(input int ch, input logic v, input string tag);
    btn_i[ch] = v;
    wait_state(ch, v, 20, tag);
  endtask

  task automatic collect_chk(input string tag, input int cycles, input int n, input int ex[6]);
    evq.delete();
    evt_ready_i = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (evt_valid_o) evq.push_back(head());
      @(negedge clk_i);
    end
    evt_ready_i = 1'b0;
    chk({tag, "_count"}, evq.size(), n);
    for (int i = 0; i < n && i < evq.size(); i++) chk($sformatf("%s_%0d", tag, i), evq[i], ex[i]);
    chk({tag, "_empty"}, int'(evt_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_state", int'(btn_state_o), 0);
    chk("rst_valid", int'(evt_valid_o), 0);
    chk("rst_id", int'(evt_id_o), 0);
    chk("rst_type", int'(evt_type_o), 0);
    chk("rst_ovf", int'(evt_overflow_o), 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // Glitch: 8 cycles high spans only two ticks.
    @(negedge clk_i);
    btn_i[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 38; i++) begin
      @(negedge clk_i);
      if (i == 7) btn_i[0] = 1'b0;
      seen = seen | evt_valid_o | btn_state_o[0];
    end
    chk("glitch_quiet", int'(seen), 0);

    // Press, hold, release on channel 1.
    btn_i[1] = 1'b1;
    wait_state(1, 1'b1, 14, "press_rise");
    chk("press_lat_v0", int'(evt_valid_o), 0);
    @(negedge clk_i);
    chk("press_head", head(), 4);
`ifdef BTN_EVT_LONG_PRESS_EN
    collect_chk("hold", 190, 2, '{4, 6, 0, 0, 0, 0});
`else
    collect_chk("hold", 190, 1, '{4, 0, 0, 0, 0, 0});
`endif
    chk("hold_state", int'(btn_state_o[1]), 1);
    btn_i[1] = 1'b0;
    wait_state(1, 1'b0, 20, "rel_fall");
    collect_chk("release", 5, 1, '{5, 0, 0, 0, 0, 0});

    // Simultaneous press on channels 0 and 3.
    evt_ready_i = 1'b1;
    btn_i[0] = 1'b1;
    btn_i[3] = 1'b1;
    wait_state(0, 1'b1, 20, "sim_rise0");
    chk("sim_rise3", int'(btn_state_o[3]), 1);
    chk("sim_v0", int'(evt_valid_o), 0);
    @(negedge clk_i);
    chk("sim_head0", head(), 0);
    @(negedge clk_i);
    chk("sim_head1", head(), 12);
    @(negedge clk_i);
    chk("sim_empty", int'(evt_valid_o), 0);
    btn_i[0] = 1'b0;
    btn_i[3] = 1'b0;
    wait_state(0, 1'b0, 20, "sim_fall0");
    collect_chk("sim_rel", 5, 2, '{1, 13, 0, 0, 0, 0});

    // Backpressure: FIFO fills with P,R,P,R; third pair pends; fourth press overflows.
    evt_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      toggle(0, 1'b1, "bp_press");
      toggle(0, 1'b0, "bp_rel");
    end
    chk("bp_ovf_before", int'(evt_overflow_o), 0);
    toggle(0, 1'b1, "bp_press4");
    chk("bp_ovf_set", int'(evt_overflow_o), 1);
    toggle(0, 1'b0, "bp_rel4");
    chk("bp_head", head(), 0);
    collect_chk("bp_drain", 20, 6, '{0, 1, 0, 1, 0, 1});
    chk("bp_ovf_sticky", int'(evt_overflow_o), 1);

    overflow_clr_i = 1'b1;
    @(negedge clk_i);
    overflow_clr_i = 1'b0;
    chk("clr_alone", int'(evt_overflow_o), 0);

    // Clear coincident with a drop: flip lands 12 edges after the previous flip.
    for (int k = 0; k < 3; k++) begin
      toggle(0, 1'b1, "co_press");
      toggle(0, 1'b0, "co_rel");
    end
    chk("co_ovf_pre", int'(evt_overflow_o), 0);
    btn_i[0] = 1'b1;
    repeat (11) @(negedge clk_i);
    overflow_clr_i = 1'b1;
    @(negedge clk_i);
    overflow_clr_i = 1'b0;
    chk("co_flip", int'(btn_state_o[0]), 1);
    chk("co_ovf_kept", int'(evt_overflow_o), 1);
    @(negedge clk_i);
    chk("co_ovf_hold", int'(evt_overflow_o), 1);
    toggle(0, 1'b0, "co_rel4");
    collect_chk("co_drain", 20, 6, '{0, 1, 0, 1, 0, 1});

    // Reset mid-operation with two events queued.
    toggle(2, 1'b1, "rs_press");
    toggle(2, 1'b0, "rs_rel");
    @(negedge clk_i);
    chk("rs_pre_head", head(), 8);
    chk("rs_pre_ovf", int'(evt_overflow_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rs_state", int'(btn_state_o), 0);
    chk("rs_valid", int'(evt_valid_o), 0);
    chk("rs_id", int'(evt_id_o), 0);
    chk("rs_type", int'(evt_type_o), 0);
    chk("rs_ovf", int'(evt_overflow_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    evt_ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      seen = seen | evt_valid_o | (|btn_state_o) | evt_overflow_o;
    end
    chk("rs_quiet", int'(seen), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
